// File: rtl/ro_sample_ctrl.sv
// Ring-oscillator sampling controller: windows ro_count into 32-bit samples and packs them
// into 512-bit lines for DMA. Optional macro RO_SAMPLE_TIMESTAMP_EN adds a per-line timestamp.
module ro_sample_ctrl #(
    parameter int SIZE_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [SIZE_WIDTH-1:0] num_samples,
    input  logic [SIZE_WIDTH-1:0] collect_cycles,
    input  logic [CNT_WIDTH-1:0]  ro_count,
    output logic [511:0]          wr_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic                  done,
    output logic                  overflow,
    output logic [1:0]            dbg_state
);

    // Handshake: a line transfers on any rising edge where wr_valid and wr_ready are both high;
    // wr_data/wr_valid hold steady while wr_valid=1 and wr_ready=0.
    typedef enum logic [1:0] {IDLE = 2'd0, WINDOW = 2'd1, FLUSH = 2'd2} state_t;

`ifdef RO_SAMPLE_TIMESTAMP_EN
    localparam logic [3:0] LAST_IDX = 4'd14;
`else
    localparam logic [3:0] LAST_IDX = 4'd15;
`endif

    state_t                state_q, state_d;
    logic [SIZE_WIDTH-1:0] num_q, num_d, coll_q, coll_d;
    logic [SIZE_WIDTH-1:0] win_cnt_q, win_cnt_d, line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0]  base_q, base_d;
    logic [3:0]            samp_idx_q, samp_idx_d;
    logic [511:0]          line_buf_q, line_buf_d, wr_data_q, wr_data_d;
    logic                  wr_valid_q, wr_valid_d, done_q, done_d, overflow_q, overflow_d;
`ifdef RO_SAMPLE_TIMESTAMP_EN
    logic [31:0]           ts_q, ts_d;
`endif

    logic [CNT_WIDTH-1:0]  diff;
    logic [31:0]           samp32;
    logic [511:0]          line_next;
    logic [SIZE_WIDTH-1:0] eff_len;
    logic                  win_close, out_free;

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        coll_d     = coll_q;
        win_cnt_d  = win_cnt_q;
        line_cnt_d = line_cnt_q;
        base_d     = base_q;
        samp_idx_d = samp_idx_q;
        line_buf_d = line_buf_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = wr_valid_q;
        done_d     = done_q;
        overflow_d = overflow_q;

        // Unsigned subtraction absorbs a single wrap of ro_count.
        diff      = ro_count - base_q;
        samp32    = 32'(diff);
        line_next = line_buf_q;
        line_next[{samp_idx_q, 5'b0} +: 32] = samp32;
`ifdef RO_SAMPLE_TIMESTAMP_EN
        ts_d = ts_q + 32'd1;
        line_next[511:480] = ts_q + 32'd1;
`endif
        eff_len   = (coll_q == '0) ? SIZE_WIDTH'(1) : coll_q;
        win_close = (win_cnt_q == eff_len - SIZE_WIDTH'(1));
        out_free  = !wr_valid_q || wr_ready;

        if (wr_valid_q && wr_ready) wr_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    num_d      = num_samples;
                    coll_d     = collect_cycles;
                    overflow_d = 1'b0;
                    base_d     = ro_count;
                    win_cnt_d  = '0;
                    line_cnt_d = '0;
                    samp_idx_d = '0;
                    line_buf_d = '0;
`ifdef RO_SAMPLE_TIMESTAMP_EN
                    ts_d       = '0;
`endif
                    done_d     = (num_samples == '0);
                    if (num_samples != '0) state_d = WINDOW;
                end
            end
            WINDOW: begin
                if (win_close) begin
                    win_cnt_d = '0;
                    base_d    = ro_count;
                    if (samp_idx_q == LAST_IDX) begin
                        samp_idx_d = '0;
                        line_buf_d = '0;
                        line_cnt_d = line_cnt_q + SIZE_WIDTH'(1);
                        if (out_free) begin
                            wr_data_d  = line_next;
                            wr_valid_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                        if (line_cnt_q + SIZE_WIDTH'(1) == num_q) state_d = FLUSH;
                    end else begin
                        samp_idx_d = samp_idx_q + 4'd1;
                        line_buf_d = line_next;
                    end
                end else begin
                    win_cnt_d = win_cnt_q + SIZE_WIDTH'(1);
                end
            end
            FLUSH: begin
                if (out_free) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            num_q      <= '0;
            coll_q     <= '0;
            win_cnt_q  <= '0;
            line_cnt_q <= '0;
            base_q     <= '0;
            samp_idx_q <= '0;
            line_buf_q <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef RO_SAMPLE_TIMESTAMP_EN
            ts_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            coll_q     <= coll_d;
            win_cnt_q  <= win_cnt_d;
            line_cnt_q <= line_cnt_d;
            base_q     <= base_d;
            samp_idx_q <= samp_idx_d;
            line_buf_q <= line_buf_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
`ifdef RO_SAMPLE_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    assign wr_data   = wr_data_q;
    assign wr_valid  = wr_valid_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ro_sample_ctrl.sv
// Directed bench for ro_sample_ctrl: base, wrap, backpressure, zero, busy-go and reset cases.
module tb_ro_sample_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         go = 1'b0;
    logic [31:0]  num_samples = '0;
    logic [31:0]  collect_cycles = '0;
    logic [31:0]  ro_count = '0;
    logic [511:0] wr_data;
    logic         wr_valid;
    logic         wr_ready = 1'b1;
    logic         done;
    logic         overflow;
    logic [1:0]   dbg_state;

    logic [31:0]  ro_step = 32'd3;
    int           checks = 0;
    int           failures = 0;
    int           lines_seen = 0;
    int           extra_lines = 0;
    logic [511:0] exp_q[$];

`ifdef RO_SAMPLE_TIMESTAMP_EN
    localparam int SPL = 15;
`else
    localparam int SPL = 16;
`endif

    ro_sample_ctrl dut (
        .clk(clk), .rst_n(rst_n), .go(go), .num_samples(num_samples),
        .collect_cycles(collect_cycles), .ro_count(ro_count), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .done(done), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] make_line(input logic [31:0] sample, input logic [31:0] ts);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < SPL; k++) l[k*32 +: 32] = sample;
`ifdef RO_SAMPLE_TIMESTAMP_EN
        l[511:480] = ts;
`endif
        return l;
    endfunction

    // Expected lines: each window spans len cycles, line k closes at (k+1)*SPL*len.
    task automatic push_lines(input int n, input logic [31:0] sample, input int len);
        for (int k = 0; k < n; k++) exp_q.push_back(make_line(sample, 32'((k + 1) * SPL * len)));
    endtask

    // Inputs change only 1ns after a rising edge; ro_count advances every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        ro_count = ro_count + ro_step;
    endtask

    task automatic start(input logic [31:0] n, input logic [31:0] c);
        go = 1'b1;
        num_samples = n;
        collect_cycles = c;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, done, 1'b1);
    endtask

    task automatic end_run(input string tag, input int lines_exp);
        check_eq({tag, "_lines"}, lines_seen, lines_exp);
        check_eq({tag, "_extra"}, extra_lines, 0);
        check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
        lines_seen = 0;
        extra_lines = 0;
        exp_q.delete();
    endtask

    // Scoreboard: at the falling edge, a valid&ready pair transfers on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && wr_valid && wr_ready) begin
            lines_seen++;
            if (exp_q.size() > 0) check_eq("line_data", wr_data, exp_q.pop_front());
            else extra_lines++;
        end
    end

    initial begin
        repeat (3) tick();
        check_eq("rst_valid", wr_valid, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_data", wr_data, '0);
        check_eq("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;
        tick();

        // Base: +3 per cycle, 10-cycle windows, 2 lines of 30.
        ro_step = 32'd3;
        push_lines(2, 32'd30, 10);
        start(32'd2, 32'd10);
        check_eq("base_state_window", dbg_state, 2'd1);
        wait_done(1000, "base_done");
        check_eq("base_overflow", overflow, 1'b0);
        check_eq("base_state_idle", dbg_state, 2'd0);
        end_run("base", 2);

        // Wrap: counter crosses 2^32 inside the first window.
        ro_count = 32'hFFFF_FFF0;
        ro_step = 32'd2;
        push_lines(1, 32'd32, 16);
        start(32'd1, 32'd16);
        wait_done(1000, "wrap_done");
        check_eq("wrap_overflow", overflow, 1'b0);
        end_run("wrap", 1);

        // Backpressure: first line held, the other two dropped.
        ro_step = 32'd3;
        wr_ready = 1'b0;
        start(32'd3, 32'd1);
        repeat (400) tick();
        check_eq("bp_valid_held", wr_valid, 1'b1);
        check_eq("bp_data_held", wr_data, make_line(32'd3, 32'(SPL)));
        check_eq("bp_overflow", overflow, 1'b1);
        check_eq("bp_done_pending", done, 1'b0);
        check_eq("bp_state_flush", dbg_state, 2'd2);
        push_lines(1, 32'd3, 1);
        wr_ready = 1'b1;
        wait_done(20, "bp_done");
        check_eq("bp_overflow_sticky", overflow, 1'b1);
        check_eq("bp_valid_clear", wr_valid, 1'b0);
        end_run("bp", 1);

        // num_samples = 0: done the cycle after go, no line.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("zero_pre_done", done, 1'b0);
        start(32'd0, 32'd5);
        check_eq("zero_done", done, 1'b1);
        check_eq("zero_state", dbg_state, 2'd0);
        repeat (10) tick();
        check_eq("zero_valid", wr_valid, 1'b0);
        end_run("zero", 0);

        // collect_cycles = 0 behaves as 1.
        ro_step = 32'd5;
        push_lines(1, 32'd5, 1);
        start(32'd1, 32'd0);
        wait_done(100, "c0_done");
        end_run("c0", 1);

        // Busy: go mid-window is ignored; done cleared by the accepted go.
        ro_step = 32'd3;
        push_lines(2, 32'd30, 10);
        start(32'd2, 32'd10);
        check_eq("busy_done_cleared", done, 1'b0);
        repeat (25) tick();
        start(32'd1, 32'd1);
        check_eq("busy_state", dbg_state, 2'd1);
        wait_done(1000, "busy_done");
        end_run("busy", 2);

        // Reset mid-operation with a held line pending.
        wr_ready = 1'b0;
        start(32'd4, 32'd2);
        repeat (50) tick();
        check_eq("rstmid_pre_valid", wr_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_valid", wr_valid, 1'b0);
        check_eq("rstmid_done", done, 1'b0);
        check_eq("rstmid_overflow", overflow, 1'b0);
        check_eq("rstmid_data", wr_data, '0);
        check_eq("rstmid_state", dbg_state, 2'd0);
        tick();
        rst_n = 1'b1;
        wr_ready = 1'b1;
        repeat (40) tick();
        check_eq("rstmid_no_resume", wr_valid, 1'b0);
        check_eq("rstmid_idle", dbg_state, 2'd0);
        end_run("rstmid", 0);
        push_lines(1, 32'd30, 10);
        start(32'd1, 32'd10);
        wait_done(1000, "restart_done");
        check_eq("restart_overflow", overflow, 1'b0);
        end_run("restart", 1);

        // Short windows: timestamp 60 when the timestamp build is used.
        ro_step = 32'd1;
        push_lines(1, 32'd4, 4);
        start(32'd1, 32'd4);
        wait_done(500, "ts_done");
        end_run("ts", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ro_sample_ctrl.md
RO_SAMPLE_CTRL -- requirements
Module: ro_sample_ctrl

Interface
REQ-001 SHALL have parameter SIZE_WIDTH, default 32, width of num_samples and collect_cycles.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of ro_count and of each packed sample.
REQ-003 SHALL have port clk  in  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port go  in  1  single-cycle start pulse from the MMIO register map.
REQ-006 SHALL have port num_samples  in  SIZE_WIDTH  number of 512-bit cache lines to produce.
REQ-007 SHALL have port collect_cycles  in  SIZE_WIDTH  length of one measurement window, in clk cycles.
REQ-008 SHALL have port ro_count  in  CNT_WIDTH  free-running ring-oscillator edge count, already synchronous to clk.
REQ-009 SHALL have port wr_data  out  512  packed cache line to the DMA write path.
REQ-010 SHALL have port wr_valid  out  1  wr_data holds a line.
REQ-011 SHALL have port wr_ready  in  1  DMA write path accepts a line when wr_valid and wr_ready are both high.
REQ-012 SHALL have port done  out  1  sticky completion flag read back over MMIO.
REQ-013 SHALL have port overflow  out  1  sticky flag: at least one line was dropped.

Function
REQ-014 SHALL implement states IDLE, WINDOW and FLUSH.
REQ-015 In IDLE, go=1 SHALL do all of the following on the next edge: latch num_samples and collect_cycles, clear done and overflow, load base <= ro_count, and enter WINDOW.
REQ-016 go SHALL be ignored in WINDOW and FLUSH.
REQ-017 The effective window length SHALL be max(collect_cycles,1).
REQ-018 In WINDOW, a window counter SHALL close a window every effective-length cycles.
REQ-019 At each window close, sample = ro_count - base, modulo 2^CNT_WIDTH, so one wrap of ro_count is handled correctly.
REQ-020 At each window close, base <= ro_count in the same cycle, so windows are back-to-back with no gap.
REQ-021 Samples SHALL pack little-endian: sample k of a line occupies wr_data[32k+31:32k], using the low 32 bits when CNT_WIDTH>32 and zero-extending when CNT_WIDTH<32.
REQ-022 A line SHALL be complete after 16 samples.
REQ-023 On line completion, if the output register is empty or being accepted in that same cycle, the line SHALL load into wr_data and wr_valid=1 on the next cycle.
REQ-024 Otherwise the new line SHALL be dropped, overflow set, and the held line left unchanged.
REQ-025 wr_data and wr_valid SHALL remain stable while wr_valid=1 and wr_ready=0.
REQ-026 The produced-line counter SHALL count both loaded and dropped lines.
REQ-027 When the produced-line count equals the latched num_samples, windowing SHALL stop and the state SHALL move to FLUSH.
REQ-028 In FLUSH, done SHALL assert the cycle after wr_valid is low or is accepted, and the state SHALL return to IDLE.
REQ-029 num_samples=0 SHALL set done one cycle after go, produce no line, and return to IDLE.
REQ-030 done and overflow SHALL hold until the next accepted go.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE and clear wr_valid, wr_data, done, overflow, all counters, base and the latched configuration, including mid-operation.
REQ-032 A line pending at reset SHALL be discarded.
REQ-033 Operation SHALL resume only on a go after rst_n returns high.

Configuration
REQ-034 With macro RO_SAMPLE_TIMESTAMP_EN defined, a line SHALL be complete after 15 samples.
REQ-035 With RO_SAMPLE_TIMESTAMP_EN defined, wr_data[511:480] SHALL carry a 32-bit clk-cycle timestamp, zeroed at go, captured at the line's last window close.
REQ-036 Without RO_SAMPLE_TIMESTAMP_EN, lines SHALL hold 16 samples and no timestamp logic is present.

Verification
REQ-037 Base case: ro_count +3 per cycle, collect_cycles=10, num_samples=2, wr_ready=1 -> 2 lines, every sample 30, done=1, overflow=0.
REQ-038 Wrap: ro_count starts 0xFFFF_FFF0, +2 per cycle, collect_cycles=16 -> all samples 32 across the wrap.
REQ-039 Backpressure: wr_ready=0 for 400 cycles, collect_cycles=1, num_samples=3 -> line 1 held stable, lines 2-3 dropped, overflow=1, done after line 1 accepted.
REQ-040 Zero cases: num_samples=0 -> done one cycle after go, wr_valid never high; collect_cycles=0 -> behaves as 1.
REQ-041 Busy and reset: go pulsed mid-WINDOW -> ignored; rst_n low mid-WINDOW -> wr_valid=0, done=0 immediately, new go restarts cleanly.
REQ-042 Timestamp: with RO_SAMPLE_TIMESTAMP_EN, collect_cycles=4, num_samples=1 -> 15 samples, wr_data[511:480]=60.
